// File: rtl/seq_muldiv_if.sv
// Operand/result bundle between a requester and the sequential multiply/divide unit.
// Requester drives start/op/Yin_data/Bus_data; the unit returns Zhigh/Zlow/busy/done/div_zero.
// start is only honoured while busy is low; done is a one-cycle pulse marking fresh results.
interface seq_muldiv_if;
  logic        start;
  logic        op;
  logic [31:0] Yin_data;
  logic [31:0] Bus_data;
  logic [31:0] Zhigh;
  logic [31:0] Zlow;
  logic        busy;
  logic        done;
  logic        div_zero;

  modport master (
    output start, op, Yin_data, Bus_data,
    input  Zhigh, Zlow, busy, done, div_zero
  );

  modport slave (
    input  start, op, Yin_data, Bus_data,
    output Zhigh, Zlow, busy, done, div_zero
  );
endinterface

// File: rtl/seq_muldiv.sv
// Sequential signed 32x32 Booth multiplier and 32/32 restoring divider (truncating).
// Latency from sampling edge to DONE entry: mul 33, div 34, divide-by-zero 1 edge.
// No backpressure: start is ignored while busy; results hold until the next DONE entry.
// Ports: Clock, clear (sync, active-low); bus (slave): start/op/Yin_data/Bus_data in,
//        Zhigh/Zlow (registered result), busy, done (1-cycle pulse), div_zero out.
module seq_muldiv (
  input  logic        Clock,
  input  logic        clear,
  seq_muldiv_if.slave bus
);

  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  // acc: Booth partial product (33b so subtracting 0x80000000 cannot overflow),
  //      or partial remainder when dividing.
  logic [32:0] acc_q, acc_d;
  // mcand: sign-extended multiplicand, or zero-extended divisor magnitude.
  logic [32:0] mcand_q, mcand_d;
  // qreg: multiplier shifting out / product low half, or dividend shifting out / quotient.
  logic [31:0] qreg_q, qreg_d;
  logic        qm1_q, qm1_d;
  logic        neg_quo_q, neg_quo_d;
  logic        neg_rem_q, neg_rem_d;
  logic [31:0] zhigh_q, zhigh_d;
  logic [31:0] zlow_q, zlow_d;
  logic        div_zero_q, div_zero_d;

  logic [32:0] booth_sum;
  logic [32:0] div_sh;
  logic [32:0] div_trial;
  logic [31:0] abs_a;
  logic [31:0] abs_b;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    mcand_d    = mcand_q;
    qreg_d     = qreg_q;
    qm1_d      = qm1_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    zhigh_d    = zhigh_q;
    zlow_d     = zlow_q;
    div_zero_d = div_zero_q;

    // Magnitudes as unsigned: 0x80000000 negates to itself, which is the correct magnitude.
    abs_a = bus.Yin_data[31] ? (32'd0 - bus.Yin_data) : bus.Yin_data;
    abs_b = bus.Bus_data[31] ? (32'd0 - bus.Bus_data) : bus.Bus_data;

    // Booth radix-2: inspect {q0, q-1}; 01 adds, 10 subtracts the multiplicand.
    case ({qreg_q[0], qm1_q})
      2'b01:   booth_sum = acc_q + mcand_q;
      2'b10:   booth_sum = acc_q - mcand_q;
      default: booth_sum = acc_q;
    endcase

    // Restoring step. Divisor magnitude <= 2^31 keeps the remainder below 2^31,
    // so bit 32 of the trial difference is purely the borrow.
    div_sh    = {acc_q[31:0], qreg_q[31]};
    div_trial = div_sh - mcand_q;

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          cnt_d      = 6'd0;
          div_zero_d = 1'b0;
          if (!bus.op) begin
            state_d = MUL;
            acc_d   = 33'd0;
            mcand_d = {bus.Yin_data[31], bus.Yin_data};
            qreg_d  = bus.Bus_data;
            qm1_d   = 1'b0;
          end else if (bus.Bus_data == 32'd0) begin
            state_d    = DONE;
            zhigh_d    = bus.Yin_data;
            zlow_d     = 32'hFFFF_FFFF;
            div_zero_d = 1'b1;
          end else begin
            state_d   = DIV;
            acc_d     = 33'd0;
            mcand_d   = {1'b0, abs_b};
            qreg_d    = abs_a;
            neg_quo_d = bus.Yin_data[31] ^ bus.Bus_data[31];
            neg_rem_d = bus.Yin_data[31];
          end
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end

      MUL: begin
        // Arithmetic shift right of {acc, qreg, q-1} by one.
        acc_d  = {booth_sum[32], booth_sum[32:1]};
        qreg_d = {booth_sum[0], qreg_q[31:1]};
        qm1_d  = qreg_q[0];
        if (cnt_q == 6'd31) begin
          state_d = DONE;
          cnt_d   = 6'd0;
          zhigh_d = booth_sum[32:1];
          zlow_d  = {booth_sum[0], qreg_q[31:1]};
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end

      DIV: begin
        if (!div_trial[32]) begin
          acc_d  = div_trial;
          qreg_d = {qreg_q[30:0], 1'b1};
        end else begin
          acc_d  = div_sh;
          qreg_d = {qreg_q[30:0], 1'b0};
        end
        if (cnt_q == 6'd31) begin
          state_d = FIX;
          cnt_d   = 6'd0;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end

      FIX: begin
        // Truncating division: quotient sign = sign(A)^sign(B), remainder follows the dividend.
        state_d = DONE;
        zlow_d  = neg_quo_q ? (32'd0 - qreg_q) : qreg_q;
        zhigh_d = neg_rem_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!clear) begin
      state_q    <= IDLE;
      cnt_q      <= 6'd0;
      acc_q      <= 33'd0;
      mcand_q    <= 33'd0;
      qreg_q     <= 32'd0;
      qm1_q      <= 1'b0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      zhigh_q    <= 32'd0;
      zlow_q     <= 32'd0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      mcand_q    <= mcand_d;
      qreg_q     <= qreg_d;
      qm1_q      <= qm1_d;
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
      zhigh_q    <= zhigh_d;
      zlow_q     <= zlow_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign bus.Zhigh    = zhigh_q;
  assign bus.Zlow     = zlow_q;
  assign bus.div_zero = div_zero_q;
  assign bus.done     = (state_q == DONE);
  assign bus.busy     = (state_q == MUL) || (state_q == DIV) || (state_q == FIX);

endmodule

// File: tb/tb_seq_muldiv.sv
// Scoreboard bench for seq_muldiv: directed vectors with hand-computed results.
module tb_seq_muldiv;

  logic Clock;
  logic clear;
  seq_muldiv_if bus ();

  seq_muldiv dut (
    .Clock (Clock),
    .clear (clear),
    .bus   (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          lat;
    int          s_edge;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge Clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every done cycle pops one expected result.
  always @(negedge Clock) begin
    if (bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1, expected no result (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("Zhigh", 64'(bus.Zhigh), 64'(e.hi));
        chk("Zlow", 64'(bus.Zlow), 64'(e.lo));
        chk("div_zero", 64'(bus.div_zero), 64'(e.dz));
        chk("latency", 64'(cyc - e.s_edge + 1), 64'(e.lat));
        chk("busy_in_done", 64'(bus.busy), 64'd0);
      end
    end
  end

  task automatic issue(input logic o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ehi, input logic [31:0] elo,
                       input logic edz, input int elat, input bit expect_it);
    exp_t e;
    bus.start    = 1'b1;
    bus.op       = o;
    bus.Yin_data = a;
    bus.Bus_data = b;
    if (expect_it) begin
      e.hi = ehi; e.lo = elo; e.dz = edz; e.lat = elat; e.s_edge = cyc + 1;
      sb.push_back(e);
    end
    @(negedge Clock);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (bus.done !== 1'b1 && n < 100) begin
      @(negedge Clock);
      n++;
    end
    if (bus.done !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL timeout_%s: got no done after %0d cycles, expected done", name, n);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bc;
    int n;
    clear = 1'b0;
    bus.start = 1'b0;
    bus.op = 1'b0;
    bus.Yin_data = 32'd0;
    bus.Bus_data = 32'd0;
    repeat (3) @(negedge Clock);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_dz", 64'(bus.div_zero), 64'd0);
    chk("rst_zhigh", 64'(bus.Zhigh), 64'd0);
    chk("rst_zlow", 64'(bus.Zlow), 64'd0);
    clear = 1'b1;
    @(negedge Clock);

    // 12*5 with busy-width measurement
    issue(1'b0, 32'd12, 32'd5, 32'h0, 32'h3C, 1'b0, 33, 1'b1);
    bc = 0;
    n = 0;
    while (bus.done !== 1'b1 && n < 100) begin
      if (bus.busy === 1'b1) bc++;
      @(negedge Clock);
      n++;
    end
    chk("mul_busy_cycles", 64'(bc), 64'd32);

    // back-to-back in DONE; previous result must hold while busy
    issue(1'b0, 32'hFFFF_FFF9, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 33, 1'b1);
    repeat (4) @(negedge Clock);
    chk("hold_zlow", 64'(bus.Zlow), 64'h3C);
    chk("hold_zhigh", 64'(bus.Zhigh), 64'h0);
    wait_done("mul_neg");

    @(negedge Clock);
    issue(1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0, 33, 1'b1);
    wait_done("mul_min");
    issue(1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, 1'b0, 33, 1'b1);
    wait_done("mul_max");
    issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1, 1'b0, 33, 1'b1);
    wait_done("mul_m1");

    // divides
    @(negedge Clock);
    issue(1'b1, 32'hFFFF_FFEF, 32'd5, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, 34, 1'b1);
    wait_done("div_neg");
    issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, 34, 1'b1);
    wait_done("div_ovf");
    issue(1'b1, 32'd100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFF2, 1'b0, 34, 1'b1);
    wait_done("div_negb");
    issue(1'b1, 32'h1234, 32'd0, 32'h1234, 32'hFFFF_FFFF, 1'b1, 1, 1'b1);
    wait_done("div_zero");
    // div_zero must clear on the next accepted start
    issue(1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFF2, 1'b0, 34, 1'b1);
    chk("dz_cleared", 64'(bus.div_zero), 64'd0);
    wait_done("div_nega");

    // start while busy is ignored
    @(negedge Clock);
    issue(1'b0, 32'd12, 32'd5, 32'h0, 32'h3C, 1'b0, 33, 1'b1);
    repeat (8) @(negedge Clock);
    bus.start = 1'b1;
    bus.op = 1'b0;
    bus.Yin_data = 32'd99;
    bus.Bus_data = 32'd5;
    @(negedge Clock);
    bus.start = 1'b0;
    wait_done("mul_ignore");

    // abort a divide with clear
    @(negedge Clock);
    issue(1'b1, 32'd1000, 32'd3, 32'h0, 32'h0, 1'b0, 0, 1'b0);
    repeat (13) @(negedge Clock);
    clear = 1'b0;
    @(negedge Clock);
    clear = 1'b1;
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_done", 64'(bus.done), 64'd0);
    chk("abort_zhigh", 64'(bus.Zhigh), 64'd0);
    chk("abort_zlow", 64'(bus.Zlow), 64'd0);
    chk("abort_dz", 64'(bus.div_zero), 64'd0);
    repeat (30) @(negedge Clock);
    issue(1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 34, 1'b1);
    wait_done("div_100_7");

    // clear wins over start on the same edge
    @(negedge Clock);
    clear = 1'b0;
    bus.start = 1'b1;
    bus.op = 1'b0;
    @(negedge Clock);
    clear = 1'b1;
    bus.start = 1'b0;
    chk("clr_prio_busy", 64'(bus.busy), 64'd0);
    @(negedge Clock);
    chk("clr_prio_busy2", 64'(bus.busy), 64'd0);

    repeat (5) @(negedge Clock);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_muldiv.md
SEQ_MULDIV -- requirements
Module: seq_muldiv

Interface
REQ-001 SHALL have port: Clock  input  1  single rising-edge clock for all state.
REQ-002 SHALL have port: clear  input  1  reset, synchronous, active-low.
REQ-003 SHALL have port: start  input  1  request; sampled on rising edge only while busy=0.
REQ-004 SHALL have port: op  input  1  0 = signed multiply, 1 = signed divide; sampled with start.
REQ-005 SHALL have port: Yin_data  input  32  operand A from Y register (multiplicand / dividend); sampled with start.
REQ-006 SHALL have port: Bus_data  input  32  operand B from bus (multiplier / divisor); sampled with start.
REQ-007 SHALL have port: Zhigh  output  32  product[63:32] or remainder; registered.
REQ-008 SHALL have port: Zlow  output  32  product[31:0] or quotient; registered.
REQ-009 SHALL have port: busy  output  1  high while an operation is in progress.
REQ-010 SHALL have port: done  output  1  one-cycle pulse; Zhigh/Zlow valid from this cycle on.
REQ-011 SHALL have port: div_zero  output  1  high with done when divide had B=0; cleared on next accepted start.

Function
REQ-012 SHALL implement FSM states IDLE, MUL, DIV, FIX, DONE; busy=1 in MUL, DIV, FIX only.
REQ-013 SHALL accept start in IDLE or DONE; start while busy=1 SHALL be ignored with no side effect.
REQ-014 IDLE/DONE + start, op=0 -> MUL; op=1, B!=0 -> DIV; op=1, B=0 -> DONE; DONE without start -> IDLE.
REQ-015 Multiply SHALL use radix-2 Booth recoding, one bit per cycle, 32 cycles in MUL, then DONE.
REQ-016 Multiply result SHALL be the exact signed 64-bit product {Zhigh,Zlow} = A*B.
REQ-017 Divide SHALL iterate one quotient bit per cycle on operand magnitudes, 32 cycles in DIV, then one cycle in FIX for sign correction, then DONE.
REQ-018 Divide SHALL truncate toward zero: Zlow = quotient, Zhigh = remainder, remainder sign equals dividend sign, |remainder| < |B|.
REQ-019 0x80000000 / 0xFFFFFFFF SHALL give Zlow=0x80000000, Zhigh=0, div_zero=0.
REQ-020 Divide by zero SHALL give Zlow=0xFFFFFFFF, Zhigh=A, div_zero=1.
REQ-021 Latency, counted in rising edges from the edge sampling start to the edge entering DONE: multiply 33, divide 34, divide-by-zero 1.
REQ-022 done SHALL be high exactly in the DONE cycle; never high in any other state.
REQ-023 Zhigh/Zlow SHALL change only on the edge entering DONE (or reset) and SHALL hold their values through subsequent busy periods until the next result.
REQ-024 Back-to-back start asserted in the DONE cycle SHALL be accepted with no idle cycle.
REQ-025 Internal iteration counter SHALL be 6 bits wide and SHALL not wrap within an operation.

Reset
REQ-026 clear=0 at a rising edge SHALL force state IDLE, busy=0, done=0, div_zero=0, Zhigh=0, Zlow=0, counter=0.
REQ-027 clear=0 during MUL/DIV/FIX SHALL abort the operation with no done pulse and no output update.
REQ-028 clear SHALL take priority over start on the same edge.

Verification
REQ-029 op=0, A=12, B=5, start -> done at edge 33, Zhigh=0x00000000, Zlow=0x0000003C, busy high for 32 cycles.
REQ-030 op=0, A=-7, B=3 -> Zhigh=0xFFFFFFFF, Zlow=0xFFFFFFEB; op=0, A=B=0x80000000 -> Zhigh=0x40000000, Zlow=0.
REQ-031 op=1, A=-17, B=5 -> done at edge 34, Zlow=0xFFFFFFFD, Zhigh=0xFFFFFFFE; A=0x80000000, B=-1 -> Zlow=0x80000000, Zhigh=0.
REQ-032 op=1, A=0x1234, B=0 -> done 1 edge after start, div_zero=1, Zlow=0xFFFFFFFF, Zhigh=0x1234.
REQ-033 start multiply 12*5, pulse start again at cycle 10 with A=99 -> second start ignored, result 0x3C at edge 33.
REQ-034 start divide, clear=0 at cycle 15 -> no done pulse, outputs 0, busy=0; then 100/7 -> Zlow=14, Zhigh=2.
